lut_table_loader: RTL and testbench

Upstream programming stage for serial_load_lut. It accepts one table entry at a time over a valid/ready handshake and serializes the full 2**IN_WIDTH x OUT_WIDTH table onto the LUT's d/cs_n pins, ordered so each entry lands in its correct slot. It runs in the same clock domain as the LUT; lut_d and lut_cs_n connect directly to the LUT's d and cs_n inputs.

---
 rtl/lut_loader_pkg.sv | 27 ++
 rtl/lut_word_serializer.sv | 41 ++++
 rtl/lut_table_loader.sv | 125 ++++++++++++
 tb/tb_lut_table_loader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/lut_loader_pkg.sv
// Shared types and sizing helpers for the LUT table loader.
package lut_loader_pkg;

    // Loader sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of entries in a table addressed by an in_width-bit select.
    function automatic int table_entries(input int in_width);
        return 1 << in_width;
    endfunction

    // Total number of bits held by the table.
    function automatic int table_bits(input int in_width, input int out_width);
        return (1 << in_width) * out_width;
    endfunction

    // Bits needed for a counter that spans 0 .. n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lut_word_serializer.sv
// W-bit parallel-load shift register, MSB first, with a bit counter that
// flags the final bit of the current word.
module lut_word_serializer
    import lut_loader_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb,
    output logic         bit_zero
);

    localparam int BW = cnt_width(W);

    logic [W-1:0]  shreg_q;
    logic [BW-1:0] bit_cnt_q;

    // Load a fresh word, or move the next bit into the MSB position.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else if (load) begin
            shreg_q   <= din;
            bit_cnt_q <= BW'(W - 1);
        end else if (shift) begin
            shreg_q <= shreg_q << 1;
            if (bit_cnt_q != '0) begin
                bit_cnt_q <= bit_cnt_q - 1'b1;
            end
        end
    end

    assign msb      = shreg_q[W-1];
    assign bit_zero = (bit_cnt_q == '0);

endmodule

// File: rtl/lut_table_loader.sv
// Serializes a full 2**IN_WIDTH x OUT_WIDTH table onto the LUT d/cs_n pins.
// Words arrive highest entry first over a valid/ready handshake.
// Optional: define LUT_TABLE_LOADER_PARITY_EN to add a parity output.
//
// Handshake: a word transfers on a rising edge where in_valid and in_ready
// are both high and abort is low; in_ready depends only on state, and
// in_data is ignored in every other cycle.
module lut_table_loader
    import lut_loader_pkg::*;
#(
    parameter int IN_WIDTH  = 4,
    parameter int OUT_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [OUT_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 lut_d,
    output logic                 lut_cs_n,
    output logic                 busy,
    output logic                 done,
`ifdef LUT_TABLE_LOADER_PARITY_EN
    output logic                 parity,
`endif
    output state_t               dbg_state
);

    localparam int N  = table_entries(IN_WIDTH);
    localparam int EW = cnt_width(N);

    state_t        state_q, state_d;
    logic [EW-1:0] entry_cnt_q;
    logic          accept;
    logic          last_entry;
    logic          ser_msb;
    logic          ser_bit_zero;
    logic          ser_shift;

    assign accept     = (state_q == LOAD) && in_valid && !abort;
    assign last_entry = (entry_cnt_q == '0);
    assign ser_shift  = (state_q == SHIFT);
    assign dbg_state  = state_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and state-decoded outputs; abort overrides everything.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        lut_cs_n = 1'b1;
        lut_d    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) state_d = SHIFT;
            end
            SHIFT: begin
                lut_cs_n = 1'b0;
                lut_d    = ser_msb;
                if (ser_bit_zero) state_d = last_entry ? DONE : LOAD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // Entry counter: counts down from N-1 as each word finishes shifting.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            entry_cnt_q <= '0;
        end else if (state_q == IDLE && start) begin
            entry_cnt_q <= EW'(N - 1);
        end else if (state_q == SHIFT && ser_bit_zero && !last_entry) begin
            entry_cnt_q <= entry_cnt_q - 1'b1;
        end
    end

    lut_word_serializer #(
        .W(OUT_WIDTH)
    ) u_serializer (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift    (ser_shift),
        .din      (in_data),
        .msb      (ser_msb),
        .bit_zero (ser_bit_zero)
    );

`ifdef LUT_TABLE_LOADER_PARITY_EN
    logic parity_q;

    // Running XOR of every bit shifted out; cleared when a load begins or is cancelled.
    always_ff @(posedge clk) begin
        if (rst || abort || (state_q == IDLE && start)) begin
            parity_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            parity_q <= parity_q ^ ser_msb;
        end
    end

    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_lut_table_loader.sv
// Bench for lut_table_loader: vector table of load scenarios plus hand
// sequences for reset, start/abort interaction and reset mid-load.
module tb_lut_table_loader;
    import lut_loader_pkg::*;

    localparam int IW = 4;
    localparam int OW = 3;
    localparam int N  = 16;
    localparam int TB = 48;

    logic          clk = 1'b0;
    logic          rst, start, abort, in_valid;
    logic [OW-1:0] in_data;
    logic          in_ready, lut_d, lut_cs_n, busy, done;
    state_t        dbg_state;
`ifdef LUT_TABLE_LOADER_PARITY_EN
    logic          parity;
`endif

    always #5 clk = ~clk;

    lut_table_loader #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lut_d     (lut_d),
        .lut_cs_n  (lut_cs_n),
        .busy      (busy),
        .done      (done),
`ifdef LUT_TABLE_LOADER_PARITY_EN
        .parity    (parity),
`endif
        .dbg_state (dbg_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference LUT: a plain N*W-bit shift chain fed from lut_d while cs_n is low.
    logic [TB-1:0] lut_bits = '0;
    int            cs_low_cnt = 0;
    int            done_cnt = 0;
    int            cs_in_load_cnt = 0;

    always @(negedge clk) begin
        if (!lut_cs_n) begin
            lut_bits   = {lut_bits[TB-2:0], lut_d};
            cs_low_cnt = cs_low_cnt + 1;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (in_ready === 1'b1 && lut_cs_n !== 1'b1) cs_in_load_cnt = cs_in_load_cnt + 1;
    end

    logic [OW-1:0] tbl [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one load; gap<0 picks a random 0..3 stall before each word.
    task automatic do_load(input int gap, input bit start_mid, input int abort_after,
                           output int cycles, output bit finished, output int total_gap);
        int  idx, waited, tgt, shifts;
        bit  in_load;
        logic exp_par;
        idx = N - 1; waited = 0; tgt = 0; shifts = 0; in_load = 0;
        cycles = 0; finished = 0; total_gap = 0;
        exp_par = 1'b0;
        for (int i = 0; i < N; i++) exp_par = exp_par ^ (^tbl[i]);
        @(negedge clk);
        start = 1'b1; abort = 1'b0; in_valid = 1'b0;
        for (int m = 1; m <= 400; m++) begin
            @(negedge clk);
            start    = 1'b0;
            abort    = 1'b0;
            in_data  = OW'($urandom);
            in_valid = 1'($urandom);
`ifdef LUT_TABLE_LOADER_PARITY_EN
            if (m == 1) chk("parity_cleared_on_start", 32'(parity), 0);
`endif
            if (done === 1'b1) begin
                cycles   = m + 1;
                finished = 1;
                in_valid = 1'b0;
`ifdef LUT_TABLE_LOADER_PARITY_EN
                chk("parity_at_done", 32'(parity), 32'(exp_par));
`endif
                break;
            end
            if (lut_cs_n === 1'b0) begin
                shifts++;
                if (start_mid && shifts == 2) start = 1'b1;
                if (abort_after > 0 && shifts == abort_after) begin
                    abort    = 1'b1;
                    in_valid = 1'b0;
                    break;
                end
            end
            if (in_ready === 1'b1) begin
                if (!in_load) begin
                    in_load = 1;
                    waited  = 0;
                    tgt     = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
                    total_gap += tgt;
                end
                if (waited < tgt) begin
                    in_valid = 1'b0;
                    waited++;
                end else begin
                    in_valid = 1'b1;
                    in_data  = tbl[idx];
                    if (idx > 0) idx--;
                    in_load  = 0;
                end
            end
        end
    endtask

    typedef struct {
        int gap;
        bit rand_tbl;
        bit start_mid;
        int abort_after;
        int exp_cs_low;
        bit exp_done;
        int exp_cycles;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int  cycles, total_gap, cs0, dn0, exp_cyc;
        bit  finished;
        vecs[0] = '{0,  0, 0, 0,  48, 1, 66};
        vecs[1] = '{3,  0, 0, 0,  48, 1, 114};
        vecs[2] = '{0,  0, 1, 0,  48, 1, 66};
        vecs[3] = '{0,  0, 0, 10, 10, 0, -1};
        vecs[4] = '{0,  0, 0, 0,  48, 1, 66};
        vecs[5] = '{-1, 1, 0, 0,  48, 1, -1};
        vecs[6] = '{-1, 1, 1, 0,  48, 1, -1};
        vecs[7] = '{2,  1, 0, 0,  48, 1, 98};

        // Reset state.
        rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_cs_n", 32'(lut_cs_n), 1);
        chk("rst_d", 32'(lut_d), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef LUT_TABLE_LOADER_PARITY_EN
        chk("rst_parity", 32'(parity), 0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // start together with abort in IDLE: nothing begins.
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 32'(busy), 0);
        chk("start_abort_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        chk("start_abort_still_idle", 32'(dbg_state), 32'(IDLE));

        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N; i++)
                tbl[i] = vecs[v].rand_tbl ? OW'($urandom) : OW'((i * 5) & 7);
            cs0 = cs_low_cnt;
            dn0 = done_cnt;
            do_load(vecs[v].gap, vecs[v].start_mid, vecs[v].abort_after, cycles, finished, total_gap);
            if (vecs[v].abort_after > 0) begin
                @(negedge clk);
                chk($sformatf("v%0d_abort_state", v), 32'(dbg_state), 32'(IDLE));
                chk($sformatf("v%0d_abort_cs_n", v), 32'(lut_cs_n), 1);
                chk($sformatf("v%0d_abort_busy", v), 32'(busy), 0);
                chk($sformatf("v%0d_abort_done", v), 32'(done), 0);
            end
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_cs_low_cycles", v), 32'(cs_low_cnt - cs0), 32'(vecs[v].exp_cs_low));
            chk($sformatf("v%0d_done_pulses", v), 32'(done_cnt - dn0), 32'(vecs[v].exp_done));
            chk($sformatf("v%0d_finished", v), 32'(finished), 32'(vecs[v].exp_done));
            if (vecs[v].exp_done) begin
                exp_cyc = (vecs[v].exp_cycles >= 0) ? vecs[v].exp_cycles
                                                    : 1 + N * (OW + 1) + total_gap + 1;
                chk($sformatf("v%0d_load_cycles", v), 32'(cycles), 32'(exp_cyc));
                for (int i = 0; i < N; i++)
                    chk($sformatf("v%0d_entry%0d", v, i), 32'(lut_bits[i*OW +: OW]), 32'(tbl[i]));
            end
            if (v == 0) begin
                chk("readback_sel9", 32'(lut_bits[9*OW +: OW]), 5);
                chk("readback_sel0", 32'(lut_bits[0 +: OW]), 0);
                chk("readback_sel15", 32'(lut_bits[15*OW +: OW]), 3);
            end
        end
        chk("cs_low_while_loading", 32'(cs_in_load_cnt), 0);

        // Reset mid-LOAD with a word offered: it must not be accepted.
        cs0 = cs_low_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10 && in_ready !== 1'b1; k++) @(negedge clk);
        chk("mid_load_reached", 32'(in_ready), 1);
        in_valid = 1'b1; in_data = 3'd5; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 0);
        chk("midrst_cs_n", 32'(lut_cs_n), 1);
        chk("midrst_d", 32'(lut_d), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_state", 32'(dbg_state), 32'(IDLE));
        repeat (3) @(negedge clk);
        chk("midrst_no_shift", 32'(cs_low_cnt - cs0), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
